// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
// Shares one router core-injection port among NREQ local requesters.
// Round-robin selection between packets; a multi-flit packet locks the port
// to its owner and VC until the tail flit is accepted.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   req_valid/req_data  per-requester flit presentation (32 bits per requester)
//   req_vc/req_last     head-flit target VC (2 bits per requester), tail marker
//   req_ready           combinational accept strobe, one-hot or zero
//   full_out_core_vc    router core-input VC full flags
//   data_in_core        registered flit (IDLE_WORD when nothing is accepted)
//   busy                high while a multi-flit packet owns the port
//   grant_id            current owner / last granted requester
//   flit_count          per-requester saturating accept counters
//                       (present only with NOC_INJ_STATS_EN defined)
module noc_inject_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter logic [31:0] IDLE_WORD = 32'h6000_0000
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [32*NREQ-1:0]       req_data,
    input  logic [2*NREQ-1:0]        req_vc,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic [3:0]               full_out_core_vc,
    output logic [31:0]              data_in_core,
    output logic                     busy,
`ifdef NOC_INJ_STATS_EN
    output logic [16*NREQ-1:0]       flit_count,
`endif
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [1:0]       vc_q, vc_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [31:0]      data_q, data_d;
    logic             busy_q, busy_d;

    logic             cand_found;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   scan_idx;
    logic [1:0]       cand_vc;
    logic [NREQ-1:0]  ready_c;
    logic             acc_c;
    logic [IDW-1:0]   acc_id_c;

    // Round-robin scan starting one past the last packet winner
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            scan_idx = IDW'((32'(rr_q) + i) % NREQ);
            if (!cand_found && req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand       = scan_idx;
            end
        end
        cand_vc = req_vc[32'(cand)*2 +: 2];
    end

    // Grant, next-state and output-register logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        vc_d     = vc_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        data_d   = IDLE_WORD;
        busy_d   = busy_q;
        ready_c  = '0;
        acc_c    = 1'b0;
        acc_id_c = cand;

        case (state_q)
            S_IDLE: begin
                // A full VC stalls the selected requester; nobody else is tried
                if (cand_found && !full_out_core_vc[cand_vc]) begin
                    ready_c[cand] = 1'b1;
                    acc_c         = 1'b1;
                    acc_id_c      = cand;
                end
            end
            S_LOCK: begin
                if (req_valid[owner_q] && !full_out_core_vc[vc_q]) begin
                    ready_c[owner_q] = 1'b1;
                    acc_c            = 1'b1;
                    acc_id_c         = owner_q;
                end
            end
            default: ;
        endcase

        if (acc_c) begin
            data_d  = req_data[32'(acc_id_c)*32 +: 32];
            grant_d = acc_id_c;
            if (state_q == S_IDLE) begin
                if (req_last[acc_id_c]) begin
                    rr_d = acc_id_c;
                end else begin
                    state_d = S_LOCK;
                    owner_d = acc_id_c;
                    vc_d    = cand_vc;
                end
            end else if (req_last[acc_id_c]) begin
                state_d = S_IDLE;
                rr_d    = owner_q;
            end
        end

        busy_d = (state_d == S_LOCK);
    end

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            vc_q    <= '0;
            rr_q    <= IDW'(NREQ - 1);
            grant_q <= '0;
            data_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            vc_q    <= vc_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    // Ready is forced low during reset so nothing is accepted before clr drops
    assign req_ready    = clr ? '0 : ready_c;
    assign data_in_core = data_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;

`ifdef NOC_INJ_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    // Saturating per-requester accept counters
    always_comb begin
        for (int unsigned r = 0; r < NREQ; r++) begin
            cnt_d[r] = cnt_q[r];
            if (acc_c && (acc_id_c == IDW'(r)) && (cnt_q[r] != 16'hFFFF)) begin
                cnt_d[r] = cnt_q[r] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt
        assign flit_count[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Testbench for noc_inject_arbiter: randomized requesters driving packets,
// a packet-level reference model producing per-cycle expectations into a
// queue, and a monitor that pops and compares at each falling edge.
module tb_noc_inject_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam logic [31:0] IDLE = 32'h6000_0000;

    logic                 clk = 1'b0;
    logic                 clr = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [32*NREQ-1:0]   req_data = '0;
    logic [2*NREQ-1:0]    req_vc = '0;
    logic [NREQ-1:0]      req_last = '0;
    logic [NREQ-1:0]      req_ready;
    logic [3:0]           full_out_core_vc = '0;
    logic [31:0]          data_in_core;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
`ifdef NOC_INJ_STATS_EN
    logic [16*NREQ-1:0]   flit_count;
`endif

    always #5 clk = ~clk;

    noc_inject_arbiter #(.NREQ(NREQ), .IDLE_WORD(IDLE)) dut (
        .clk              (clk),
        .clr              (clr),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_vc           (req_vc),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .full_out_core_vc (full_out_core_vc),
        .data_in_core     (data_in_core),
        .busy             (busy),
`ifdef NOC_INJ_STATS_EN
        .flit_count       (flit_count),
`endif
        .grant_id         (grant_id)
    );

    typedef struct packed {
        logic [NREQ-1:0]    ready;
        logic [31:0]        data;
        logic               busy;
        logic [IDW-1:0]     grant;
        logic [16*NREQ-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Requester traffic generator state
    int          pv = 100;     // percent chance a requester presents its flit
    int          pf = 0;       // percent chance each VC full flag is set
    int          maxlen = 1;   // longest packet in flits
    int          p_len [NREQ];
    int          p_pos [NREQ];
    logic [1:0]  p_vc  [NREQ];
    logic [31:0] p_flit[NREQ];

    // Reference model: arbitration seen as packets taking turns
    bit          m_locked;
    int          m_owner;
    logic [1:0]  m_vc;
    int          m_rr;
    int          m_grant;
    logic [31:0] m_data;
    int          m_cnt[NREQ];

    function automatic void new_pkt(input int r);
        p_len[r]  = int'($urandom_range(maxlen, 1));
        p_pos[r]  = 0;
        p_vc[r]   = 2'($urandom_range(3));
        p_flit[r] = $urandom;
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_vc     = 2'd0;
        m_rr     = NREQ - 1;
        m_grant  = 0;
        m_data   = IDLE;
        for (int r = 0; r < NREQ; r++) begin
            m_cnt[r] = 0;
            new_pkt(r);
        end
    endfunction

    // Drive one cycle of stimulus 2 time units after the rising edge, record
    // the expectation for this cycle, then advance the model over the next edge.
    task automatic drive_cycle(input logic c);
        exp_t e;
        int   acc;
        bit   last;
        @(posedge clk);
        #2;
        clr = c;
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]        = (int'($urandom_range(99)) < pv);
            req_data[32*r +: 32] = p_flit[r];
            req_last[r]         = (p_pos[r] == p_len[r] - 1);
            req_vc[2*r +: 2]    = (p_pos[r] == 0) ? p_vc[r] : 2'($urandom_range(3));
        end
        for (int k = 0; k < 4; k++) begin
            full_out_core_vc[k] = (int'($urandom_range(99)) < pf);
        end

        if (c) model_reset();

        acc = -1;
        if (!c) begin
            if (!m_locked) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int cidx;
                    cidx = (m_rr + k) % NREQ;
                    if (req_valid[cidx]) begin
                        if (!full_out_core_vc[req_vc[2*cidx +: 2]]) acc = cidx;
                        break;
                    end
                end
            end else if (req_valid[m_owner] && !full_out_core_vc[m_vc]) begin
                acc = m_owner;
            end
        end

        e.ready = '0;
        if (acc >= 0) e.ready[acc] = 1'b1;
        e.data  = m_data;
        e.busy  = m_locked;
        e.grant = IDW'(m_grant);
        for (int r = 0; r < NREQ; r++) e.cnt[16*r +: 16] = 16'(m_cnt[r]);
        exp_q.push_back(e);

        if (!c) begin
            m_data = IDLE;
            if (acc >= 0) begin
                m_data  = p_flit[acc];
                m_grant = acc;
                if (m_cnt[acc] < 65535) m_cnt[acc]++;
                last = (p_pos[acc] == p_len[acc] - 1);
                if (!m_locked) begin
                    if (last) m_rr = acc;
                    else begin
                        m_locked = 1'b1;
                        m_owner  = acc;
                        m_vc     = p_vc[acc];
                    end
                end else if (last) begin
                    m_locked = 1'b0;
                    m_rr     = acc;
                end
                if (last) new_pkt(acc);
                else begin
                    p_pos[acc]++;
                    p_flit[acc] = $urandom;
                end
            end
        end
    endtask

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_ready",    64'(req_ready),    64'(e.ready));
                check("data_in_core", 64'(data_in_core), 64'(e.data));
                check("busy",         64'(busy),         64'(e.busy));
                check("grant_id",     64'(grant_id),     64'(e.grant));
`ifdef NOC_INJ_STATS_EN
                check("flit_count",   64'(flit_count),   64'(e.cnt));
`endif
            end
        end
    end

    // Stimulus sequence
    initial begin
        model_reset();
        repeat (3) drive_cycle(1'b1);

        // All requesters valid with single-flit packets: plain rotation 0,1,2,3,0
        pv = 100; pf = 0; maxlen = 1;
        repeat (6) drive_cycle(1'b0);

        // Multi-flit packets with everyone competing and no back-pressure
        maxlen = 3;
        repeat (60) drive_cycle(1'b0);

        // Mixed traffic: dropped valids, VC back-pressure, varied lengths
        pv = 75; pf = 20; maxlen = 4;
        repeat (1500) drive_cycle(1'b0);

        // Reset in the middle of an open packet
        pv = 100; pf = 0; maxlen = 5;
        for (int t = 0; t < 200 && !m_locked; t++) drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b1);
        maxlen = 1;
        repeat (6) drive_cycle(1'b0);

        // Heavy back-pressure and long packets
        pv = 60; pf = 50; maxlen = 6;
        repeat (1000) drive_cycle(1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of local requesters sharing one router core-injection port (2..8).
REQ-002 SHALL have parameter IDLE_WORD, default 32'h60000000: word driven on the injection port when no flit is sent.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  bit r: requester r presents a flit.
REQ-006 SHALL have port req_data  input  32*NREQ  flit of requester r in bits [32r+31:32r].
REQ-007 SHALL have port req_vc  input  2*NREQ  target VC of requester r (0..3 maps to VC1..VC4), sampled on head flit only.
REQ-008 SHALL have port req_last  input  NREQ  bit r: presented flit is the packet tail.
REQ-009 SHALL have port req_ready  output  NREQ  bit r: flit of requester r is accepted this cycle; combinational, at most one bit high.
REQ-010 SHALL have port full_out_core_vc  input  4  router core-input VC full flags, bit k = VC(k+1).
REQ-011 SHALL have port data_in_core  output  32  registered flit to the router core input.
REQ-012 SHALL have port busy  output  1  high while a multi-flit packet holds the port.
REQ-013 SHALL have port grant_id  output  $clog2(NREQ)  current owner/last granted requester.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no packet open) and LOCK (multi-flit packet open, owner and VC latched).
REQ-015 In IDLE, SHALL select the first requester with req_valid high, searching round-robin from rr_ptr+1 modulo NREQ.
REQ-016 SHALL assert req_ready[sel] in IDLE only if full_out_core_vc[req_vc[sel]] is low; a full VC blocks selection that cycle (no skipping to another requester).
REQ-017 A flit is accepted iff req_valid[r] and req_ready[r]; data_in_core SHALL equal that flit on the next clock edge (latency 1).
REQ-018 In any cycle with no accepted flit, data_in_core SHALL take IDLE_WORD on the next edge.
REQ-019 Accepted head flit with req_last low SHALL move IDLE->LOCK, latching owner=r and vc=req_vc[r]; busy and grant_id update on the same edge.
REQ-020 Accepted head flit with req_last high (single-flit packet) SHALL stay IDLE and set rr_ptr=r.
REQ-021 In LOCK, only the owner SHALL be granted, with ready = req_valid[owner] and not full_out_core_vc[latched vc]; other requesters' req_vc ignored.
REQ-022 In LOCK, owner dropping req_valid SHALL hold LOCK and emit IDLE_WORD; no timeout.
REQ-023 Accepted flit with req_last high in LOCK SHALL return to IDLE, set rr_ptr=owner, deassert busy on that edge.
REQ-024 Full flag toggling mid-packet SHALL only stall (ready low), never drop or duplicate a flit.

Reset
REQ-025 While clr high: state=IDLE, rr_ptr=NREQ-1 (so requester 0 wins first), data_in_core=IDLE_WORD, busy=0, grant_id=0, req_ready=0.
REQ-026 clr asserted mid-packet SHALL abandon the packet immediately; no tail flit is generated.
REQ-027 After clr deasserts, first acceptance SHALL occur no earlier than the first rising edge with clr low.

Configuration
REQ-028 With macro NOC_INJ_STATS_EN defined, SHALL add output flit_count  16*NREQ  per-requester accepted-flit counters, saturating at 16'hFFFF, cleared by clr.
REQ-029 Without NOC_INJ_STATS_EN, SHALL have no flit_count port and no counter logic; all other behaviour identical.

Verification
REQ-030 After reset, req_valid=4'b1111, all single-flit, VCs empty -> grants 0,1,2,3,0 on consecutive cycles; data_in_core follows 1 cycle later.
REQ-031 Req 2 sends 3-flit packet on VC3 while req 0,1 valid -> flits of req 2 contiguous, busy=1 for 2 cycles, then grant to req 3 (or 0), never 0/1 mid-packet.
REQ-032 full_out_core_vc=4'b0100 during req 2 packet body for 3 cycles -> req_ready=0, data_in_core=32'h60000000 those cycles, remaining flits resume unchanged.
REQ-033 Owner drops req_valid for 2 cycles mid-packet -> busy stays 1, 2 idle words output, no other requester granted.
REQ-034 clr pulsed during LOCK -> busy=0, data_in_core=32'h60000000 asynchronously; next grant goes to requester 0.
REQ-035 With NOC_INJ_STATS_EN, 5 flits from req 1 -> flit_count[31:16]=5, others 0; counter preloaded near max stops at 16'hFFFF.
